punc_mem_arbiter: RTL and testbench
===================================

Name: punc_mem_arbiter

Overview:
Shares the single memory port of the PUnC LC3 processor between two requesters: the CPU (control unit fetch, load and store accesses) and a debug/loader port used for program load and inspection.
- Arbitrates with round-robin priority.
- Sequences each access through issue, read-latency wait and completion states.
- Returns read data and a done pulse to the winning requester.
- Sits between the PUnC control/datapath and the memory.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
RD_LAT, 2, memory read latency in cycles after the mem_en cycle; legal range 1..7

Ports:
clk  in  1  clock
rst  in  1  reset
cpu_req  in  1  CPU access request; held high until cpu_done
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  in  ADDR_W  CPU address; stable while cpu_req is high
cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req is high
cpu_gnt  out  1  one-cycle pulse: CPU access issued to memory
cpu_done  out  1  one-cycle pulse: CPU access complete
cpu_rdata  out  DATA_W  CPU read data; valid with cpu_done and held until the next CPU read completes
dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug-port equivalents of the cpu_* inputs
dbg_gnt, dbg_done, dbg_rdata  out  1/1/DATA_W  debug-port equivalents of the cpu_* outputs
dbg_lock  in  1  when high, the CPU is ineligible for grant (debug halt)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the mem_en cycle
busy  out  1  arbiter is in an access (ISSUE, WAIT or DONE)

Behaviour:
Reset and clocking
- Reset rst, synchronous, active-high; clock clk.
- Reset values: state = IDLE; all gnt/done outputs, mem_en, mem_we and busy = 0; mem_addr, mem_wdata, cpu_rdata and dbg_rdata = 0; last_winner = DBG, so the CPU wins the first tie.

State machine: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - CPU is eligible iff cpu_req && !dbg_lock; debug is eligible iff dbg_req.
  - One eligible requester: it wins.
  - Both eligible: the requester not equal to last_winner wins.
  - On a win: latch the winner's we/addr/wdata, update last_winner, go to ISSUE.
  - No eligible requester: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched values.
  - The winner's gnt pulses.
  - Write goes to DONE. Read loads the counter with RD_LAT and goes to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, capture mem_rdata into the winner's rdata register and go to DONE.
  - WAIT therefore lasts exactly RD_LAT cycles.
- DONE (1 cycle): the winner's done pulses, then go to IDLE.
- Outside ISSUE, mem_en, mem_we, mem_addr and mem_wdata are driven to 0.

Latency
- Request first seen in IDLE at cycle 0: gnt at cycle 1.
- Write done at cycle 2; read done at cycle RD_LAT+2.
- At least one IDLE cycle separates consecutive accesses.

Handshake rules
- The requester deasserts req in the cycle following done unless it wants a new access.
- req still high in the IDLE cycle after done is treated as a new request.
- Dropping req before grant cancels it: no gnt and no done.
- Dropping req after gnt does not abort the access: it completes and done still pulses.

Boundary conditions
- dbg_lock rising while a CPU access is in progress does not abort it; it only affects the next arbitration.
- The rdata of the non-winning port is never modified.
- rst during ISSUE, WAIT or DONE: next cycle is IDLE with all outputs at reset values; no done is issued for the aborted access.
- RD_LAT = 1: WAIT lasts 1 cycle.
- Counter width is 3 bits.

Test Plan:
1. RD_LAT=2, cpu_req read of addr 0x3000 at cycle 0, mem returns 0x1234 -> cpu_gnt and mem_en at cycle 1 with mem_addr=0x3000 and mem_we=0; cpu_done at cycle 4 with cpu_rdata=0x1234; busy high for cycles 1-4.
2. dbg write of addr 0x0040, data 0xBEEF -> mem_en=1, mem_we=1, mem_addr=0x0040, mem_wdata=0xBEEF at cycle 1; dbg_done at cycle 2; dbg_rdata unchanged.
3. After reset, cpu_req and dbg_req (both reads) rise together and are re-requested continuously -> grant order CPU, DBG, CPU, DBG, each done preceding the next gnt by at least 1 IDLE cycle.
4. dbg_lock=1 with both requesting continuously -> only dbg_gnt pulses and CPU waits; dbg_lock drops -> CPU wins the next arbitration.
5. rst asserted in the 2nd WAIT cycle of a CPU read -> next cycle state IDLE, mem_en=0, cpu_done never pulses, cpu_rdata=0.
6. RD_LAT=1 build, CPU read of 0x3001 returning 0x00FF -> cpu_gnt at cycle 1, cpu_done at cycle 3 with cpu_rdata=0x00FF.

Source files
------------

// File: rtl/punc_mem_arbiter_if.sv
// Bundle of the two requester ports, the debug lock and the single memory port
// shared by the PUnC memory arbiter.
interface punc_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Handshake: a requester raises req with we/addr/wdata stable and holds it
  // until its done pulse; gnt pulses when the access reaches memory. Dropping
  // req before gnt cancels the request, dropping it after gnt does not abort.
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_lock;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    output dbg_gnt, dbg_done, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/punc_mem_arbiter.sv
// Round-robin arbiter sharing the PUnC memory port between the CPU and the
// debug/loader port; each access runs IDLE -> ISSUE -> (WAIT) -> DONE.
module punc_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2   // legal range 1..7, fits the 3-bit counter
) (
  input  logic               clk,
  input  logic               rst,
  punc_mem_arbiter_if.master bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_t     state;
  logic       last_dbg;  // 1 = debug port won the previous arbitration
  logic       win_dbg;   // owner of the access in flight
  logic [2:0] cnt;

  logic cpu_elig;
  logic dbg_elig;
  logic pick_cpu;

  assign cpu_elig  = bus.cpu_req && !bus.dbg_lock;
  assign dbg_elig  = bus.dbg_req;
  assign pick_cpu  = cpu_elig && (!dbg_elig || last_dbg);
  assign state_dbg = state;

  // The mem_* registers double as the latched request: they are loaded on the
  // win and only hold non-zero values during the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_dbg      <= 1'b1;
      win_dbg       <= 1'b0;
      cnt           <= 3'd0;
      bus.cpu_gnt   <= 1'b0;
      bus.cpu_done  <= 1'b0;
      bus.cpu_rdata <= {DATA_W{1'b0}};
      bus.dbg_gnt   <= 1'b0;
      bus.dbg_done  <= 1'b0;
      bus.dbg_rdata <= {DATA_W{1'b0}};
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.busy      <= 1'b0;
    end else begin
      bus.cpu_gnt   <= 1'b0;
      bus.dbg_gnt   <= 1'b0;
      bus.cpu_done  <= 1'b0;
      bus.dbg_done  <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      case (state)
        IDLE: begin
          if (cpu_elig || dbg_elig) begin
            state      <= ISSUE;
            bus.busy   <= 1'b1;
            bus.mem_en <= 1'b1;
            win_dbg    <= !pick_cpu;
            last_dbg   <= !pick_cpu;
            if (pick_cpu) begin
              bus.cpu_gnt   <= 1'b1;
              bus.mem_we    <= bus.cpu_we;
              bus.mem_addr  <= bus.cpu_addr;
              bus.mem_wdata <= bus.cpu_wdata;
            end else begin
              bus.dbg_gnt   <= 1'b1;
              bus.mem_we    <= bus.dbg_we;
              bus.mem_addr  <= bus.dbg_addr;
              bus.mem_wdata <= bus.dbg_wdata;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_we) begin
            state        <= DONE;
            bus.cpu_done <= !win_dbg;
            bus.dbg_done <= win_dbg;
          end else begin
            cnt   <= RD_LAT_C;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state        <= DONE;
            bus.cpu_done <= !win_dbg;
            bus.dbg_done <= win_dbg;
            if (win_dbg) bus.dbg_rdata <= bus.mem_rdata;
            else         bus.cpu_rdata <= bus.mem_rdata;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Bench for punc_mem_arbiter: directed scenarios plus randomized accesses
// checked against a transaction-level model of arbitration and latency.
module tb_punc_mem_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  punc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  punc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  logic [1:0] st;
  logic [1:0] st1;

  punc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(st));
  punc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));

  int vec_cnt = 0;
  int err_cnt = 0;

  // memory model shared by both DUT instances
  logic [DW-1:0] mem_arr [0:65535];
  logic [DW-1:0] exp_q[$];

  // reference model state
  bit            m_last_dbg;
  logic [DW-1:0] m_cpu_rdata;
  logic [DW-1:0] m_dbg_rdata;

  bit pend0, pend1;
  int due0, due1;
  logic [AW-1:0] ra0, ra1;

  // memory responders: read data appears exactly LAT cycles after mem_en
  always @(negedge clk) begin
    if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) begin
      pend0 = 1'b1; due0 = cyc + LAT; ra0 = bus.mem_addr;
    end
    if (pend0 && cyc == due0) begin
      bus.mem_rdata = mem_arr[ra0]; pend0 = 1'b0;
    end else bus.mem_rdata = 16'($urandom);
  end

  always @(negedge clk) begin
    if (bus1.mem_en && !bus1.mem_we) begin
      pend1 = 1'b1; due1 = cyc + 1; ra1 = bus1.mem_addr;
    end
    if (pend1 && cyc == due1) begin
      bus1.mem_rdata = mem_arr[ra1]; pend1 = 1'b0;
    end else bus1.mem_rdata = 16'($urandom);
  end

  // driver tasks
  task automatic drive_idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.dbg_lock = 1'b0;
    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.dbg_req = 1'b0; bus1.dbg_we = 1'b0; bus1.dbg_addr = '0; bus1.dbg_wdata = '0;
    bus1.dbg_lock = 1'b0;
  endtask

  task automatic drive_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic drive_dbg(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  task automatic model_reset();
    m_last_dbg  = 1'b1;
    m_cpu_rdata = '0;
    m_dbg_rdata = '0;
    exp_q.delete();
  endtask

  // One arbitration starting from the IDLE cycle whose inputs were just driven.
  // keep: leave requests high after done; rand_drop: random req drop / lock toggles.
  task automatic run_access(input bit keep, input bit rand_drop);
    bit ce, de, wd;
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [5:0] ctl, ex;
    int lat;
    ce = bus.cpu_req && !bus.dbg_lock;
    de = bus.dbg_req;
    if (!ce && !de) begin
      @(negedge clk);
      ctl = {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done, bus.mem_en, bus.busy};
      vec_cnt++;
      if (ctl !== 6'b0 || st !== 2'd0) begin
        err_cnt++; $display("FAIL no_req_idle got ctl=%b st=%0d exp ctl=000000 st=0", ctl, st);
      end
      return;
    end
    if (!ce)      wd = 1'b1;
    else if (!de) wd = 1'b0;
    else          wd = !m_last_dbg;
    m_last_dbg = wd;
    we  = wd ? bus.dbg_we : bus.cpu_we;
    a   = wd ? bus.dbg_addr : bus.cpu_addr;
    d   = wd ? bus.dbg_wdata : bus.cpu_wdata;
    lat = we ? 2 : LAT + 2;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      ctl = {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done, bus.mem_en, bus.busy};
      ex  = {!wd && k == 1, wd && k == 1, !wd && k == lat, wd && k == lat, k == 1, 1'b1};
      vec_cnt++;
      if (ctl !== ex) begin
        err_cnt++; $display("FAIL ctl k=%0d got=%b exp=%b", k, ctl, ex);
      end
      vec_cnt++;
      if (k == 1) begin
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {we, a, d}) begin
          err_cnt++; $display("FAIL mem_issue got we=%b a=%h d=%h exp we=%b a=%h d=%h",
                              bus.mem_we, bus.mem_addr, bus.mem_wdata, we, a, d);
        end
        if (!we) exp_q.push_back(mem_arr[a]);
      end else if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
        err_cnt++; $display("FAIL mem_quiet k=%0d got we=%b a=%h d=%h exp zeros",
                            k, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      if (k == lat && !we) begin
        if (wd) m_dbg_rdata = exp_q.pop_front();
        else    m_cpu_rdata = exp_q.pop_front();
      end
      vec_cnt++;
      if (bus.cpu_rdata !== m_cpu_rdata || bus.dbg_rdata !== m_dbg_rdata) begin
        err_cnt++; $display("FAIL rdata k=%0d got cpu=%h dbg=%h exp cpu=%h dbg=%h",
                            k, bus.cpu_rdata, bus.dbg_rdata, m_cpu_rdata, m_dbg_rdata);
      end
      if (rand_drop) begin
        bus.dbg_lock = 1'($urandom_range(0, 1));
        if (k == 1 && $urandom_range(0, 1) == 1) begin
          if (wd) bus.dbg_req = 1'b0;
          else    bus.cpu_req = 1'b0;
        end
      end
      if (k == lat && !keep) begin
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
      end
    end
    @(negedge clk);
    ctl = {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done, bus.mem_en, bus.busy};
    vec_cnt++;
    if (ctl !== 6'b0 || st !== 2'd0) begin
      err_cnt++; $display("FAIL idle_gap got ctl=%b st=%0d exp ctl=000000 st=0", ctl, st);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done, bus.mem_en, bus.mem_we, bus.busy} !== 7'b0
        || bus.mem_addr !== '0 || bus.mem_wdata !== '0 || st !== 2'd0) begin
      err_cnt++; $display("FAIL reset_ctl got en=%b we=%b busy=%b a=%h st=%0d exp all zero",
                          bus.mem_en, bus.mem_we, bus.busy, bus.mem_addr, st);
    end
    vec_cnt++;
    if (bus.cpu_rdata !== '0 || bus.dbg_rdata !== '0 || bus1.cpu_rdata !== '0) begin
      err_cnt++; $display("FAIL reset_rdata got cpu=%h dbg=%h exp 0000", bus.cpu_rdata, bus.dbg_rdata);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_cpu_read();
    mem_arr[16'h3000] = 16'h1234;
    drive_cpu(1'b0, 16'h3000, 16'h0000);
    run_access(1'b0, 1'b0);
    vec_cnt++;
    if (bus.cpu_rdata !== 16'h1234) begin
      err_cnt++; $display("FAIL cpu_read_data got=%h exp=1234", bus.cpu_rdata);
    end
  endtask

  task automatic test_dbg_write();
    drive_dbg(1'b1, 16'h0040, 16'hBEEF);
    run_access(1'b0, 1'b0);
    vec_cnt++;
    if (mem_arr[16'h0040] !== 16'hBEEF) begin
      err_cnt++; $display("FAIL dbg_write_mem got=%h exp=beef", mem_arr[16'h0040]);
    end
  endtask

  task automatic test_round_robin();
    test_reset();
    drive_cpu(1'b0, 16'h0100, '0);
    drive_dbg(1'b0, 16'h0200, '0);
    repeat (4) run_access(1'b1, 1'b0);
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    run_access(1'b0, 1'b0);
  endtask

  task automatic test_dbg_lock();
    bus.dbg_lock = 1'b1;
    drive_cpu(1'b0, 16'h0300, '0);
    drive_dbg(1'b1, 16'h0400, 16'h5555);
    repeat (3) run_access(1'b1, 1'b0);
    bus.dbg_lock = 1'b0;
    run_access(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    drive_cpu(1'b0, 16'h3000, '0);
    @(negedge clk);
    vec_cnt++;
    if (bus.cpu_gnt !== 1'b1) begin
      err_cnt++; $display("FAIL abort_gnt got=%b exp=1", bus.cpu_gnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    model_reset();
    vec_cnt++;
    if (st !== 2'd0 || bus.mem_en !== 1'b0 || bus.cpu_done !== 1'b0 || bus.cpu_rdata !== '0) begin
      err_cnt++; $display("FAIL abort_state got st=%0d en=%b done=%b rd=%h exp 0 0 0 0000",
                          st, bus.mem_en, bus.cpu_done, bus.cpu_rdata);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vec_cnt++;
      if (bus.cpu_done !== 1'b0 || bus.busy !== 1'b0) begin
        err_cnt++; $display("FAIL abort_no_done k=%0d got done=%b busy=%b exp 0 0", k, bus.cpu_done, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bus.dbg_lock = 1'($urandom_range(0, 3) == 0);
      bus.cpu_req  = 1'($urandom_range(0, 1));
      bus.cpu_we   = 1'($urandom_range(0, 1));
      bus.cpu_addr = 16'($urandom);
      bus.cpu_wdata = 16'($urandom);
      bus.dbg_req  = 1'($urandom_range(0, 1));
      bus.dbg_we   = 1'($urandom_range(0, 1));
      bus.dbg_addr = 16'($urandom_range(0, 15));
      bus.dbg_wdata = 16'($urandom);
      run_access(1'b0, 1'b1);
    end
    drive_idle();
  endtask

  task automatic test_rd_lat1();
    logic [3:0] ctl, ex;
    mem_arr[16'h3001] = 16'h00FF;
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h3001;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ctl = {bus1.cpu_gnt, bus1.cpu_done, bus1.mem_en, bus1.busy};
      ex  = {k == 1, k == 3, k == 1, k <= 3};
      vec_cnt++;
      if (ctl !== ex) begin
        err_cnt++; $display("FAIL lat1_ctl k=%0d got=%b exp=%b", k, ctl, ex);
      end
      if (k == 3) begin
        bus1.cpu_req = 1'b0;
        vec_cnt++;
        if (bus1.cpu_rdata !== 16'h00FF) begin
          err_cnt++; $display("FAIL lat1_rdata got=%h exp=00ff", bus1.cpu_rdata);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'($urandom);
    pend0 = 1'b0; pend1 = 1'b0; due0 = 0; due1 = 0; ra0 = '0; ra1 = '0;
    bus.mem_rdata = '0; bus1.mem_rdata = '0;
    drive_idle();
    model_reset();
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_round_robin();
    test_dbg_lock();
    test_reset_mid_read();
    test_random();
    test_rd_lat1();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
